bitxor_inst_encoder: RTL

- Transmit side of the 2-bit bitxor instruction stream.
- Accepts one high-level job per handshake: compute L XOR R and output it.
- Expands each job into the instruction sequence SETL(L), SETR(R), XOR, OUT. Operands travel on a separate immediate field.
- Sits between the job source (host/testbench/controller) and the instruction decode/execute stage. Drives inst/imm with a valid/ready handshake.

---
 rtl/bitxor_inst_encoder_if.sv | 34 +++
 rtl/bitxor_inst_encoder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bitxor_inst_encoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bitxor_inst_encoder_if                                             |
// | Job-side and instruction-side handshake bundle for the encoder.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface bitxor_inst_encoder_if #(
   parameter int DATA_W = 1,
   parameter int CNT_W  = 8
);
   logic              job_valid;
   logic              job_ready;
   logic [DATA_W-1:0] job_l;
   logic [DATA_W-1:0] job_r;
   logic [1:0]        inst;
   logic [DATA_W-1:0] imm;
   logic              inst_valid;
   logic              inst_ready;
   logic              busy;
   logic [CNT_W-1:0]  job_count;

   // Drives jobs in and consumes instructions.
   modport master (
      output job_valid, job_l, job_r, inst_ready,
      input  job_ready, inst, imm, inst_valid, busy, job_count
   );

   // The encoder itself.
   modport slave (
      input  job_valid, job_l, job_r, inst_ready,
      output job_ready, inst, imm, inst_valid, busy, job_count
   );
endinterface
`default_nettype wire

// File: rtl/bitxor_inst_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bitxor_inst_encoder                                                |
// | Expands (L,R) jobs into SETL/SETR/XOR/OUT instruction streams.     |
// | Optional macro BITXOR_ENC_SETSKIP_EN skips redundant setters.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bitxor_inst_encoder #(
   parameter int DATA_W = 1,
   parameter int CNT_W  = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   bitxor_inst_encoder_if.slave  bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S_SETL = 3'd1,
      S_SETR = 3'd2,
      S_XOR  = 3'd3,
      S_OUT  = 3'd4
   } state_t;

   localparam logic [1:0]       c_op_xor  = 2'b00;
   localparam logic [1:0]       c_op_out  = 2'b01;
   localparam logic [1:0]       c_op_setl = 2'b10;
   localparam logic [1:0]       c_op_setr = 2'b11;
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [1:0]        inst_q, inst_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] l_q, l_d;
   logic [DATA_W-1:0] r_q, r_d;
   logic [CNT_W-1:0]  count_q;

   logic              w_ready;
   logic              w_job_take;
   logic              w_xfer;
   state_t            w_first;
   logic              w_skip_r;

`ifdef BITXOR_ENC_SETSKIP_EN
   logic [DATA_W-1:0] last_l_q;
   logic [DATA_W-1:0] last_r_q;
   logic              known_q;

   // The R comparison is safe to defer to the SETL transfer: last_r only moves on a SETR.
   always_comb begin
      w_first  = S_SETL;
      w_skip_r = known_q && (r_q == last_r_q);
      if (known_q && (bus.job_l == last_l_q)) begin
         w_first = (bus.job_r == last_r_q) ? S_XOR : S_SETR;
      end
   end
`else
   always_comb begin
      w_first  = S_SETL;
      w_skip_r = 1'b0;
   end
`endif

   always_comb begin
      w_ready    = (state_q == IDLE) || ((state_q == S_OUT) && bus.inst_ready);
      w_job_take = bus.job_valid && w_ready;
      w_xfer     = valid_q && bus.inst_ready;
      l_d        = w_job_take ? bus.job_l : l_q;
      r_d        = w_job_take ? bus.job_r : r_q;

      state_d = state_q;
      case (state_q)
         IDLE:    if (w_job_take) state_d = w_first;
         S_SETL:  if (w_xfer)     state_d = w_skip_r ? S_XOR : S_SETR;
         S_SETR:  if (w_xfer)     state_d = S_XOR;
         S_XOR:   if (w_xfer)     state_d = S_OUT;
         S_OUT:   if (w_xfer)     state_d = w_job_take ? w_first : IDLE;
         default:                 state_d = IDLE;
      endcase

      inst_d  = c_op_xor;
      imm_d   = '0;
      valid_d = (state_d != IDLE);
      case (state_d)
         S_SETL: begin
            inst_d = c_op_setl;
            imm_d  = l_d;
         end
         S_SETR: begin
            inst_d = c_op_setr;
            imm_d  = r_d;
         end
         S_OUT:   inst_d = c_op_out;
         default: inst_d = c_op_xor;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         inst_q   <= c_op_xor;
         imm_q    <= '0;
         valid_q  <= 1'b0;
         l_q      <= '0;
         r_q      <= '0;
         count_q  <= '0;
`ifdef BITXOR_ENC_SETSKIP_EN
         last_l_q <= '0;
         last_r_q <= '0;
         known_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         imm_q   <= imm_d;
         valid_q <= valid_d;
         l_q     <= l_d;
         r_q     <= r_d;
         if ((state_q == S_OUT) && w_xfer) begin
            count_q <= count_q + c_cnt_one;
         end
`ifdef BITXOR_ENC_SETSKIP_EN
         if ((state_q == S_SETL) && w_xfer) begin
            last_l_q <= l_q;
         end
         // While not yet known neither setter is skipped, so SETL has already gone out.
         if ((state_q == S_SETR) && w_xfer) begin
            last_r_q <= r_q;
            known_q  <= 1'b1;
         end
`endif
      end
   end

   assign bus.job_ready  = w_ready;
   assign bus.inst       = inst_q;
   assign bus.imm        = imm_q;
   assign bus.inst_valid = valid_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.job_count  = count_q;
endmodule
`default_nettype wire
